// File: rtl/custom_subtractor51_17_seq.sv
// ---------------------------------------------------------------------------
// custom_subtractor51_17_seq
//
// Multi-cycle subtractor: Diff = A - {17'b0, B} for a 51-bit unsigned minuend
// and a 34-bit unsigned subtrahend. The subtraction is done in three 17-bit
// chunks, least significant first, with the borrow carried between chunks in
// a register so the longest combinational path is one 17-bit subtract.
// This is the removal counterpart of the 51/17 custom adder in the
// multiplier datapath.
//
// Ports
//   clk         in   1   clock, all state changes on the rising edge
//   rst         in   1   synchronous, active-high reset
//   in_valid    in   1   A/B valid
//   in_ready    out  1   operands can be accepted (IDLE and not in reset)
//   A           in  51   minuend, unsigned
//   B           in  34   subtrahend, unsigned, zero-extended internally
//   out_valid   out  1   Diff/borrow_out valid
//   out_ready   in   1   consumer accepts the result
//   Diff        out 51   (A - B) mod 2^51
//   borrow_out  out  1   1 when A < B (borrow out of bit 50)
//
// Handshake summary
//   Accept edge -> three CALC edges -> DONE with out_valid high.
//   DONE holds until out_ready; then one IDLE cycle before the next accept.
// ---------------------------------------------------------------------------
module custom_subtractor51_17_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [50:0] A,
   input  logic [33:0] B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [50:0] Diff,
   output logic        borrow_out
);

   localparam int unsigned CHUNK = 17;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One chunk of subtraction with borrow-in. The result is CHUNK+1 bits:
   // the MSB is the borrow-out because the 18-bit difference wraps negative
   // exactly when a < b + bin.
   function automatic logic [CHUNK:0] sub_chunk(
      input logic [CHUNK-1:0] a,
      input logic [CHUNK-1:0] b,
      input logic             bin
   );
      logic [CHUNK:0] r;
      r = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
      return r;
   endfunction

   // -----------------------------------------------------------------------
   // State and datapath registers
   // -----------------------------------------------------------------------
   state_t           state_q,      state_d;
   logic [1:0]       cnt_q,        cnt_d;
   logic             brw_q,        brw_d;
   logic [50:0]      a_q,          a_d;
   logic [50:0]      b_q,          b_d;
   logic [50:0]      diff_q,       diff_d;
   logic [50:0]      diff_out_q,   diff_out_d;
   logic             borrow_out_q, borrow_out_d;
   logic             out_valid_q,  out_valid_d;

   // Chunk operands and the chunk subtract result
   logic [CHUNK-1:0] a_chunk_s;
   logic [CHUNK-1:0] b_chunk_s;
   logic [CHUNK:0]   sub_res_s;

   // Select the 17-bit slices of the operands for the current chunk
   always_comb begin
      a_chunk_s = {CHUNK{1'b0}};
      b_chunk_s = {CHUNK{1'b0}};
      case (cnt_q)
         2'd0: begin
            a_chunk_s = a_q[16:0];
            b_chunk_s = b_q[16:0];
         end
         2'd1: begin
            a_chunk_s = a_q[33:17];
            b_chunk_s = b_q[33:17];
         end
         2'd2: begin
            // b_q[50:34] is always zero, but the borrow still has to ripple
            // through this chunk, so it is subtracted like the others.
            a_chunk_s = a_q[50:34];
            b_chunk_s = b_q[50:34];
         end
         default: begin
            a_chunk_s = {CHUNK{1'b0}};
            b_chunk_s = {CHUNK{1'b0}};
         end
      endcase
   end

   assign sub_res_s = sub_chunk(a_chunk_s, b_chunk_s, brw_q);

   // Next-state logic for the FSM, chunk counter and datapath
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      brw_d        = brw_q;
      a_d          = a_q;
      b_d          = b_q;
      diff_d       = diff_q;
      diff_out_d   = diff_out_q;
      borrow_out_d = borrow_out_q;
      out_valid_d  = out_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = {17'd0, B};
               brw_d   = 1'b0;
               cnt_d   = 2'd0;
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_CALC: begin
            brw_d = sub_res_s[CHUNK];
            case (cnt_q)
               2'd0:    diff_d[16:0]  = sub_res_s[CHUNK-1:0];
               2'd1:    diff_d[33:17] = sub_res_s[CHUNK-1:0];
               2'd2:    diff_d[50:34] = sub_res_s[CHUNK-1:0];
               default: diff_d        = diff_q;
            endcase

            if (cnt_q == 2'd2) begin
               // Last chunk: publish the full result into the output
               // registers so Diff only changes when a new result lands.
               diff_out_d   = diff_d;
               borrow_out_d = sub_res_s[CHUNK];
               out_valid_d  = 1'b1;
               cnt_d        = 2'd0;
               state_d      = ST_DONE;
            end else begin
               cnt_d   = cnt_q + 2'd1;
               state_d = ST_CALC;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               // Backpressure: hold result and out_valid unchanged.
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            cnt_d       = 2'd0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous reset; reset wins over any handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 2'd0;
         brw_q        <= 1'b0;
         a_q          <= 51'd0;
         b_q          <= 51'd0;
         diff_q       <= 51'd0;
         diff_out_q   <= 51'd0;
         borrow_out_q <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         brw_q        <= brw_d;
         a_q          <= a_d;
         b_q          <= b_d;
         diff_q       <= diff_d;
         diff_out_q   <= diff_out_d;
         borrow_out_q <= borrow_out_d;
         out_valid_q  <= out_valid_d;
      end
   end

   // in_ready is combinational so it drops in the same cycle rst rises and
   // comes back in the very first cycle after rst is released.
   assign in_ready   = (state_q == ST_IDLE) && !rst;
   assign out_valid  = out_valid_q;
   assign Diff       = diff_out_q;
   assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_custom_subtractor51_17_seq.sv
// ---------------------------------------------------------------------------
// Self-checking bench for custom_subtractor51_17_seq. Expected results go
// into a scoreboard queue on the accept edge and are compared when the DUT
// hands a result over (out_valid && out_ready).
// ---------------------------------------------------------------------------
module tb_custom_subtractor51_17_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [50:0] A;
   logic [33:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [50:0] Diff;
   logic        borrow_out;

   int checks = 0;
   int errors = 0;
   int sent   = 0;
   int rcvd   = 0;
   int ready_mode = 0;   // 0: out_ready high, 1: random, 2: driven by main flow

   logic [51:0] sb_q[$]; // {borrow, diff}

   custom_subtractor51_17_seq dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (A),
      .B          (B),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .Diff       (Diff),
      .borrow_out (borrow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Consumer-side out_ready driver
   always @(posedge clk) begin
      #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
   end

   // Scoreboard compare at each result handshake, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_result", 64'(out_valid), 64'd0);
         end else begin
            logic [51:0] e;
            e = sb_q.pop_front();
            check_val("diff", 64'(Diff), 64'(e[50:0]));
            check_val("borrow", 64'(borrow_out), 64'(e[51]));
            rcvd++;
         end
      end
   end

   // Drive one operation; returns #1 after its accept edge.
   task automatic send(input logic [50:0] a, input logic [33:0] b,
                       input logic [50:0] exp_diff, input logic exp_brw);
      int n;
      A = a;
      B = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 60) begin
         check_val("accept_timeout", 64'(n), 64'd0);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         sb_q.push_back({exp_brw, exp_diff});
         sent++;
         #1;
         in_valid = 1'b0;
         // Operands are captured on the accept edge only; scramble them.
         A = {$urandom, $urandom};
         B = {$urandom, $urandom};
      end
   endtask

   task automatic send_model(input logic [50:0] a, input logic [33:0] b);
      logic [51:0] m;
      m = {1'b0, a} - {18'd0, b};
      send(a, b, m[50:0], m[51]);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("drain_in_time", 64'(n < 300), 64'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int ov_cnt;
      logic [50:0] ra;
      logic [33:0] rb;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check_val("rst_in_ready", 64'(in_ready), 64'd0);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_diff", 64'(Diff), 64'd0);
      check_val("rst_borrow", 64'(borrow_out), 64'd0);
      rst = 1'b0;
      #1;
      check_val("in_ready_after_rst", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Basic subtract with latency and single-cycle out_valid
      send(51'd100, 34'd1, 51'd99, 1'b0);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_val("latency", 64'(cyc), 64'd3);
      @(posedge clk);
      #1;
      check_val("out_valid_one_cycle", 64'(out_valid), 64'd0);
      check_val("in_ready_back", 64'(in_ready), 64'd1);
      wait_drain();

      // Underflow and cross-chunk borrows
      send(51'd0, 34'd1, 51'h7FFFFFFFFFFFF, 1'b1);
      wait_drain();
      send(51'h20000, 34'd1, 51'h1FFFF, 1'b0);
      wait_drain();
      send(51'h400000000, 34'd1, 51'h3FFFFFFFF, 1'b0);
      wait_drain();
      send(51'h400000000, 34'h3FFFFFFFF, 51'd1, 1'b0);
      wait_drain();
      send(51'd0, 34'h3FFFFFFFF, 51'h7FFFC00000001, 1'b1);
      wait_drain();

      // Backpressure: result must hold while out_ready is low
      ready_mode = 2;
      out_ready = 1'b0;
      send(51'd5, 34'd3, 51'd2, 1'b0);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_val("bp_latency", 64'(cyc), 64'd3);
      A = 51'd9; B = 34'd4; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_val("bp_out_valid", 64'(out_valid), 64'd1);
         check_val("bp_diff", 64'(Diff), 64'd2);
         check_val("bp_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);   // result handshake edge
      #1;
      check_val("bp_in_ready_after_hs", 64'(in_ready), 64'd1);
      check_val("bp_out_valid_after_hs", 64'(out_valid), 64'd0);
      sb_q.push_back({1'b0, 51'd5});
      sent++;
      @(posedge clk);   // accept edge for the held second operation
      #1;
      in_valid = 1'b0;
      check_val("bp_second_accepted", 64'(in_ready), 64'd0);
      ready_mode = 0;
      wait_drain();

      // Reset in the second CALC cycle abandons the operation
      A = 51'd1000; B = 34'd1; in_valid = 1'b1;
      @(posedge clk);   // accept
      #1;
      in_valid = 1'b0;
      @(posedge clk);   // first CALC edge; now in second CALC cycle
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("midrst_in_ready", 64'(in_ready), 64'd0);
      check_val("midrst_out_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;
      #1;
      check_val("midrst_in_ready_after", 64'(in_ready), 64'd1);
      ov_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) ov_cnt++;
      end
      check_val("midrst_no_out_valid", 64'(ov_cnt), 64'd0);
      send(51'd7, 34'd7, 51'd0, 1'b0);
      wait_drain();

      // Random operands with corner mixes and random stalls
      ready_mode = 1;
      for (int k = 0; k < 2000; k++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: ra = '1;
            1: ra = '0;
            2: rb = '1;
            3: rb = '0;
            default: ;
         endcase
         send_model(ra, rb);
      end
      ready_mode = 0;
      wait_drain();
      check_val("result_count", 64'(rcvd), 64'(sent));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
